// File: rtl/aes_sub_shift_stage.sv
// SubBytes/ShiftRows stage: substitutes LANES bytes per cycle of a captured 128-bit state,
// optionally applying ShiftRows on write-back, and holds the result on a valid/ready output.

module AES_SBox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  logic [7:0] w_x16;
  logic [7:0] w_norm;
  logic [7:0] w_norm_inv;
  logic [7:0] w_inv;

  // Subfield inversion: x^17 lies in GF(16), so x^-1 = x^16 * (x^17)^14
  always_comb begin
    w_x16      = gf_sq(gf_sq(gf_sq(gf_sq(i_a))));
    w_norm     = gf_mul(w_x16, i_a);
    w_norm_inv = gf_mul(gf_mul(gf_sq(gf_sq(gf_sq(w_norm))), gf_sq(gf_sq(w_norm))),
                        gf_sq(w_norm));
    w_inv      = gf_mul(w_x16, w_norm_inv);
    o_s        = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]} ^
                 {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_sub_shift_stage #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned SHIFT_ROWS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned C  = 16 / LANES;
  localparam int unsigned GW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grp;
  logic [7:0]      r_work [16];
  logic [7:0]      r_res  [16];
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic [3:0]      w_src [LANES];
  logic [3:0]      w_dst [LANES];
  logic [7:0]      w_sub [LANES];
  logic            w_last;

  // Byte at (row r, col c) lands at (row r, col (c - r) mod 4) when ShiftRows is on
  function automatic logic [3:0] dst_idx(input logic [3:0] i);
    logic [1:0] row;
    logic [1:0] col;
    row = i[1:0];
    col = i[3:2];
    if (SHIFT_ROWS != 0) return {2'(col - row), row};
    return i;
  endfunction

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    assign w_src[g] = 4'(32'(r_grp) * LANES + 32'(g));
    assign w_dst[g] = dst_idx(w_src[g]);
    AES_SBox u_sbox (
      .i_a (r_work[w_src[g]]),
      .o_s (w_sub[g])
    );
  end

  assign w_last = (r_grp == GW'(C - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grp       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_work[i] <= 8'h00;
        r_res[i]  <= 8'h00;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++) r_work[i] <= in_state[127-8*i -: 8];
            r_grp      <= '0;
            r_state    <= S_BUSY;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_BUSY: begin
          for (int l = 0; l < int'(LANES); l++) r_res[w_dst[l]] <= w_sub[l];
          if (w_last) begin
            r_grp       <= '0;
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_grp <= r_grp + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    out_state = '0;
    for (int i = 0; i < 16; i++) out_state[127-8*i -: 8] = r_res[i];
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_aes_sub_shift_stage.sv
// Scoreboard bench for aes_sub_shift_stage over several LANES/SHIFT_ROWS configurations.

module tb_aes_sub_shift_stage;

  localparam int NI = 6;

  logic         clk;
  logic         rst_n;
  logic         vld  [NI];
  logic         irdy [NI];
  logic [127:0] ist  [NI];
  logic         ovld [NI];
  logic         ordy [NI];
  logic [127:0] ost  [NI];
  logic         bsy  [NI];

  logic [7:0]   sb_t [256];
  logic [127:0] sb_q [$];
  int           n_chk;
  int           n_err;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aes_sub_shift_stage #(
      .LANES      ((g == 2) ? 1 : (g == 3) ? 2 : (g == 4) ? 8 : (g == 5) ? 16 : 4),
      .SHIFT_ROWS ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[g]),
      .in_ready  (irdy[g]),
      .in_state  (ist[g]),
      .out_valid (ovld[g]),
      .out_ready (ordy[g]),
      .out_state (ost[g]),
      .busy      (bsy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lanes_of(input int k);
    case (k)
      2:       return 1;
      3:       return 2;
      4:       return 8;
      5:       return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int sr_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference S-box: brute-force inverse search plus bitwise affine map
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] cst;
    cst = 8'h63;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb_t[b] = s;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st, input int sr);
    logic [127:0] o;
    int d;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      d = (sr != 0) ? 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4) : i;
      o[127-8*d -: 8] = sb_t[st[127-8*i -: 8]];
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on instance k; optional output backpressure with a second state offered
  task automatic run(input int k, input logic [127:0] st, input int hold,
                     input logic [127:0] st2, output logic [127:0] got);
    bit acc;
    int lat;
    ist[k] = st;
    vld[k] = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = irdy[k];
      @(posedge clk); #1;
    end
    chk("accept", 128'(acc), 128'd1);
    sb_q.push_back(model(st, sr_of(k)));
    vld[k] = 1'b0;
    ist[k] = {$urandom, $urandom, $urandom, $urandom};
    chk("busy", 128'(bsy[k]), 128'd1);
    lat = 0;
    while (lat < 40 && !ovld[k]) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 128'(lat), 128'(16 / lanes_of(k)));
    got = ost[k];
    if (hold > 0) begin
      vld[k] = 1'b1;
      ist[k] = st2;
      for (int n = 0; n < hold; n++) begin
        @(posedge clk); #1;
        chk("hold_state", ost[k], got);
        chk("hold_valid", 128'(ovld[k]), 128'd1);
        chk("hold_in_ready", 128'(irdy[k]), 128'd0);
      end
    end
    chk("sb_size", 128'(sb_q.size()), 128'd1);
    chk("result", got, sb_q.pop_front());
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    chk("out_valid_drop", 128'(ovld[k]), 128'd0);
    chk("in_ready_back", 128'(irdy[k]), 128'd1);
  endtask

  initial begin
    logic [127:0] got;
    logic [127:0] st;
    logic [127:0] pat;
    bit           acc;
    bit           stray;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      vld[k] = 1'b0; ordy[k] = 1'b0; ist[k] = '0;
    end
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_in_ready", 128'(irdy[k]), 128'd1);
      chk("rst_out_valid", 128'(ovld[k]), 128'd0);
      chk("rst_busy", 128'(bsy[k]), 128'd0);
      chk("rst_out_state", ost[k], 128'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 128'(irdy[0]), 128'd1);

    run(0, 128'h0, 0, 128'h0, got);
    chk("zero_sr1", got, {16{8'h63}});
    run(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 128'h0, got);
    chk("fips_sr1", got, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    run(1, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 128'h0, got);
    chk("fips_sr0", got, 128'hd42711aee0bf98f1b8b45de51e415230);

    // Backpressure: second state offered while the first is held, then accepted right after
    st = {$urandom, $urandom, $urandom, $urandom};
    run(0, 128'h00112233445566778899aabbccddeeff, 10, st, got);
    run(0, st, 0, 128'h0, got);

    pat = {4{32'h000153ff}};
    for (int k = 2; k < NI; k++) begin
      run(k, pat, 0, 128'h0, got);
      chk("lane_sweep", got, {4{32'h637ced16}});
    end

    for (int n = 0; n < 4; n++) begin
      run(n % 2, {$urandom, $urandom, $urandom, $urandom}, 0, 128'h0, got);
      run(2 + n, {$urandom, $urandom, $urandom, $urandom}, 0, 128'h0, got);
    end

    // Reset two cycles into BUSY discards the in-flight state
    ist[0] = 128'hdeadbeef0123456789abcdef55aa33cc;
    vld[0] = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = irdy[0];
      @(posedge clk); #1;
    end
    chk("mid_accept", 128'(acc), 128'd1);
    vld[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(ovld[0]), 128'd0);
    chk("mid_rst_out_state", ost[0], 128'h0);
    chk("mid_rst_in_ready", 128'(irdy[0]), 128'd1);
    chk("mid_rst_busy", 128'(bsy[0]), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (ovld[0]) stray = 1'b1;
    end
    chk("mid_rst_no_output", 128'(stray), 128'd0);
    chk("mid_rst_state_zero", ost[0], 128'h0);
    chk("mid_rst_ready", 128'(irdy[0]), 128'd1);
    run(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 128'h0, got);
    chk("post_rst_fips", got, 128'hd4bf5d30e0b452aeb84111f11e2798e5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/aes_sub_shift_stage.md
# aes_sub_shift_stage

Sequential SubBytes/ShiftRows stage of the AES round datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through LANES instances of the composite-field `AES_SBox`. It optionally applies ShiftRows on write-back and presents the result on a held valid/ready output. It sits directly upstream of MixColumns/AddRoundKey and is the only consumer of the S-box in the round datapath.

## Interface
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16. Instantiates LANES `AES_SBox` copies.
- SHIFT_ROWS, 1, 1 = output is ShiftRows(SubBytes(in)); 0 = SubBytes(in) only.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  stage can accept a state.
- in_state  input  128  input state. Byte i = in_state[127-8i -: 8]; row i%4, column i/4 (FIPS-197 column-major).
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  result, same byte ordering as in_state.
- busy  output  1  high in BUSY state.

## Operation
- Define C = 16/LANES, the number of substitution cycles.
- The FSM has three states: IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, in_state is captured into the work buffer, grp is cleared to 0, and the FSM goes to BUSY.
- BUSY:
  - Each cycle, bytes grp*LANES .. grp*LANES+LANES-1 of the captured state go through the S-boxes.
  - Each result is written into the result buffer at its destination index.
  - The grp counter (width clog2(C), minimum 1 bit) increments every cycle.
  - After the write of group C-1, the FSM goes to DONE. The counter wraps to 0; no other wrap occurs.
- Destination index: for SHIFT_ROWS = 0, byte i is written to index i. For SHIFT_ROWS = 1, source byte at (row r, column c) is written to (row r, column (c - r) mod 4), i.e. index 4*((c - r) mod 4) + r.
- DONE:
  - out_valid = 1; out_state = the result buffer.
  - On out_ready, the FSM goes to IDLE.
  - out_state and out_valid stay stable until accepted.
- in_ready = 1 only in IDLE. in_valid in BUSY or DONE is ignored and not captured; the upstream must hold it.
- out_ready outside DONE has no effect.
- The captured input buffer is not modified during BUSY, so changing in_state after the handshake has no effect.
- Reset asserted mid-operation, in any state:
  - The in-flight state is discarded with no partial output.
  - The FSM returns to IDLE.
  - All buffers clear to 0.

## Timing
- Reset values:
  - in_ready = 1 once rst_n is low.
  - out_valid = 0, busy = 0.
  - out_state = 128'h0; the result buffer is reset.
- Accept handshake at rising edge T. BUSY covers the cycles after edges T .. T+C-1. out_valid rises after edge T+C.
  - Latency is C cycles: 4 for LANES = 4, 16 for LANES = 1, 1 for LANES = 16.
- Output handshake at edge D: out_valid falls and in_ready rises after D. The next accept can occur no earlier than edge D+1.
- Maximum throughput is one state per C+2 cycles with out_ready held high.
- The S-box is purely combinational between the work buffer and the result-buffer write. There is no extra pipeline register.
- out_state is driven only from flops. No combinational path exists from any input to any output except through the FSM registers.

## Test plan
- Reset/idle: hold rst_n = 0, then release.
  - Required: in_ready = 1, out_valid = 0, busy = 0, out_state = 0.
- Zero state, LANES = 4, SHIFT_ROWS = 1: in_state = 128'h0.
  - Required: out_valid exactly 4 cycles after the accept edge, and out_state = 128'h6363...63 (all bytes 63).
- FIPS-197 App. B round 1: in_state = 193de3bea0f4e22b9ac68d2ae9f84808.
  - SHIFT_ROWS = 1 requires d4bf5d30e0b452aeb84111f11e2798e5.
  - SHIFT_ROWS = 0 requires d42711aee0bf98f1b8b45de51e415230.
- Output backpressure: hold out_ready = 0 for 10 cycles after out_valid, with in_valid held high and in_state changed during that time.
  - Required: out_state stable, in_ready = 0, new input not captured.
  - Required: after out_ready pulses, in_ready = 1 on the next cycle and the second state is accepted.
- Lane sweep: LANES = 1, 2, 8, 16 on in_state bytes 00, 01, 53, ff repeated, SHIFT_ROWS = 0.
  - Required: bytes 63, 7c, ed, 16 repeated.
  - Required: latency 16, 8, 2, 1 cycles respectively.
- Mid-operation reset: assert rst_n low 2 cycles into BUSY (LANES = 4).
  - Required: out_valid stays 0 and out_state = 0.
  - Required: after release, in_ready = 1, and a fresh state completes correctly.
